// File: rtl/d1s3208_pkg.sv
// Shared types and constants for the d1s3208 sweep controller.
package d1s3208_pkg;

  localparam int unsigned D1S3208_N_IN = 3;
  localparam int unsigned N_VEC = 2**D1S3208_N_IN;
  localparam logic [N_VEC-1:0] EXP_TT_DEFAULT = 8'hE8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } sweep_state_e;

endpackage

// File: rtl/d1s3208_sweep_ctrl_if.sv
// Bus between the sweep controller and its user: the start/result handshake
// plus the input/output lines of the combinational unit under test.
interface d1s3208_sweep_ctrl_if
  import d1s3208_pkg::*;
#(
  parameter int unsigned N_IN = D1S3208_N_IN
);

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_IN-1:0]      dut_in;
  logic                 dut_out;
  logic [N_IN:0]        err_count;
  logic [N_IN-1:0]      first_fail_idx;
  logic [2**N_IN-1:0]   captured_tt;

  // Controller side.
  modport master (
    input  start, dut_out,
    output busy, done, pass, dut_in, err_count, first_fail_idx, captured_tt
  );

  // Requester / unit-under-test side.
  modport slave (
    output start, dut_out,
    input  busy, done, pass, dut_in, err_count, first_fail_idx, captured_tt
  );

endinterface

// File: rtl/d1s3208_settle_timer.sv
// Settle-window timer: load clears, en counts, expire pulses for one cycle
// on the last counted cycle of the window and the count restarts from zero.
module d1s3208_settle_timer
  import d1s3208_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = $clog2(SETTLE_CYC) + 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count and expire pulse.
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        expire = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/d1s3208_sweep_ctrl.sv
// Self-check sequencer for the 3-input combinational unit d1s3208.
// Walks dut_in through every input value, waits a settle window, samples
// dut_out, builds the captured truth table and compares it to EXP_TT.
// Optional build macro: D1S3208_SWEEP_STOP_ON_FAIL_EN ends the sweep at the
// first mismatching vector.
module d1s3208_sweep_ctrl
  import d1s3208_pkg::*;
#(
  parameter int unsigned         N_IN       = D1S3208_N_IN,
  parameter logic [2**N_IN-1:0]  EXP_TT     = EXP_TT_DEFAULT,
  parameter int unsigned         SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  d1s3208_sweep_ctrl_if.master   bus
);

  sweep_state_e        state_q, state_d;
  logic [N_IN-1:0]     dut_in_q, dut_in_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [N_IN:0]       err_count_q, err_count_d;
  logic [N_IN-1:0]     first_fail_idx_q, first_fail_idx_d;
  logic [2**N_IN-1:0]  captured_tt_q, captured_tt_d;

  logic                tmr_load;
  logic                tmr_en;
  logic                tmr_expire;
  logic                mismatch;
  logic                last_vec;

  assign tmr_load = ((state_q == IDLE) && bus.start) || (state_q == SAMPLE);
  assign tmr_en   = (state_q == SETTLE);
  assign mismatch = (bus.dut_out != EXP_TT[dut_in_q]);
  assign last_vec = (dut_in_q == '1);

  d1s3208_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  // Sweep FSM next-state and result update. done/pass/busy are registered,
  // so done appears in the cycle after the DONE state.
  always_comb begin
    state_d          = state_q;
    dut_in_d         = dut_in_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    err_count_d      = err_count_q;
    first_fail_idx_d = first_fail_idx_q;
    captured_tt_d    = captured_tt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          err_count_d      = '0;
          captured_tt_d    = '0;
          first_fail_idx_d = '0;
          pass_d           = 1'b0;
          dut_in_d         = '0;
          busy_d           = 1'b1;
          state_d          = SETTLE;
        end
      end

      SETTLE: begin
        if (tmr_expire) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        captured_tt_d[dut_in_q] = bus.dut_out;
        if (mismatch) begin
          err_count_d = err_count_q + 1'b1;
          if (err_count_q == '0) begin
            first_fail_idx_d = dut_in_q;
          end
        end
`ifdef D1S3208_SWEEP_STOP_ON_FAIL_EN
        if (mismatch || last_vec) begin
          state_d = DONE;
        end else begin
          dut_in_d = dut_in_q + 1'b1;
          state_d  = SETTLE;
        end
`else
        if (last_vec) begin
          state_d = DONE;
        end else begin
          dut_in_d = dut_in_q + 1'b1;
          state_d  = SETTLE;
        end
`endif
      end

      DONE: begin
        done_d   = 1'b1;
        pass_d   = (err_count_q == '0);
        busy_d   = 1'b0;
        dut_in_d = '0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      dut_in_q         <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= '0;
      first_fail_idx_q <= '0;
      captured_tt_q    <= '0;
    end else begin
      state_q          <= state_d;
      dut_in_q         <= dut_in_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_count_q      <= err_count_d;
      first_fail_idx_q <= first_fail_idx_d;
      captured_tt_q    <= captured_tt_d;
    end
  end

  assign bus.dut_in         = dut_in_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_count_q;
  assign bus.first_fail_idx = first_fail_idx_q;
  assign bus.captured_tt    = captured_tt_q;

endmodule

// File: tb/tb_d1s3208_sweep_ctrl.sv
// Directed bench for d1s3208_sweep_ctrl with a switchable model of the
// combinational unit (majority / stuck-at-0 / 3-input XOR).
module tb_d1s3208_sweep_ctrl;

  logic clk;
  logic rst_n;
  int   mode;
  int   checks;
  int   failures;

  d1s3208_sweep_ctrl_if #(.N_IN(3)) bus ();

  d1s3208_sweep_ctrl #(
    .N_IN       (3),
    .EXP_TT     (8'hE8),
    .SETTLE_CYC (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the unit under test.
  always_comb begin
    case (mode)
      1:       bus.dut_out = 1'b0;
      2:       bus.dut_out = ^bus.dut_in;
      default: bus.dut_out = (bus.dut_in[2] & bus.dut_in[1]) |
                             (bus.dut_in[2] & bus.dut_in[0]) |
                             (bus.dut_in[1] & bus.dut_in[0]);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the edge that accepts start.
  task automatic pulse_start();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Cycles from the accepting edge to the first cycle with done=1; 0 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dut_in"}, 32'(bus.dut_in), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_done"}, 32'(bus.done), 32'h0);
    chk({tag, "_pass"}, 32'(bus.pass), 32'h0);
    chk({tag, "_err"}, 32'(bus.err_count), 32'h0);
    chk({tag, "_ffi"}, 32'(bus.first_fail_idx), 32'h0);
    chk({tag, "_ctt"}, 32'(bus.captured_tt), 32'h0);
  endtask

  initial begin
    int lat;
    int seq_err;
    int done_cnt;
    int d1;
    int d2;
    int exp_in;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    mode      = 0;

    // Reset state
    #12;
    chk_reset_vals("rst");
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Majority model: cycle-by-cycle dut_in/busy/done sequence
    mode = 0;
    pulse_start();
    seq_err = 0;
    d1 = 0;
    if (bus.dut_in !== 3'd0 || bus.busy !== 1'b1 || bus.done !== 1'b0) seq_err++;
    for (int n = 1; n <= 26; n++) begin
      @(posedge clk);
      #1;
      exp_in = (n >= 25) ? 0 : ((n / 3 > 7) ? 7 : n / 3);
      if (bus.dut_in !== 3'(exp_in)) seq_err++;
      if (bus.busy !== (n < 25)) seq_err++;
      if (bus.done !== (n == 25)) seq_err++;
      if (bus.done === 1'b1 && d1 == 0) begin
        d1 = n;
        chk("maj_ctt", 32'(bus.captured_tt), 32'hE8);
        chk("maj_err", 32'(bus.err_count), 32'h0);
        chk("maj_pass", 32'(bus.pass), 32'h1);
        chk("maj_ffi", 32'(bus.first_fail_idx), 32'h0);
      end
    end
    chk("maj_latency", 32'(d1), 32'd25);
    chk("maj_seq_errors", 32'(seq_err), 32'h0);

    // Stuck-at-0 model
    mode = 1;
    pulse_start();
    wait_done(lat);
`ifdef D1S3208_SWEEP_STOP_ON_FAIL_EN
    chk("s0_latency", 32'(lat), 32'd13);
    chk("s0_err", 32'(bus.err_count), 32'h1);
`else
    chk("s0_latency", 32'(lat), 32'd25);
    chk("s0_err", 32'(bus.err_count), 32'h4);
`endif
    chk("s0_ctt", 32'(bus.captured_tt), 32'h00);
    chk("s0_ffi", 32'(bus.first_fail_idx), 32'h3);
    chk("s0_pass", 32'(bus.pass), 32'h0);

    // XOR model: 8'h96 against 8'hE8 differs at vectors 1..6
    mode = 2;
    pulse_start();
    wait_done(lat);
`ifdef D1S3208_SWEEP_STOP_ON_FAIL_EN
    chk("xor_latency", 32'(lat), 32'd7);
    chk("xor_err", 32'(bus.err_count), 32'h1);
    chk("xor_ctt", 32'(bus.captured_tt), 32'h02);
`else
    chk("xor_latency", 32'(lat), 32'd25);
    chk("xor_err", 32'(bus.err_count), 32'h6);
    chk("xor_ctt", 32'(bus.captured_tt), 32'h96);
`endif
    chk("xor_ffi", 32'(bus.first_fail_idx), 32'h1);
    chk("xor_pass", 32'(bus.pass), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("xor_hold_done", 32'(bus.done), 32'h0);
    chk("xor_hold_ffi", 32'(bus.first_fail_idx), 32'h1);
    chk("xor_hold_busy", 32'(bus.busy), 32'h0);

    // start re-pulsed at cycles 5 and 12 of a sweep is ignored
    mode = 0;
    pulse_start();
    done_cnt = 0;
    d1 = 0;
    for (int n = 1; n <= 40; n++) begin
      bus.start = (n == 5 || n == 12);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (d1 == 0) d1 = n;
      end
    end
    chk("repulse_done_count", 32'(done_cnt), 32'd1);
    chk("repulse_latency", 32'(d1), 32'd25);

    // start held high: back-to-back sweeps
    d1 = 0;
    d2 = 0;
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        if (d1 == 0) d1 = n;
        else if (d2 == 0) begin
          d2 = n;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    chk("b2b_first_done", 32'(d1), 32'd25);
    chk("b2b_second_done", 32'(d2), 32'd51);
    chk("b2b_pass", 32'(bus.pass), 32'h1);
    chk("b2b_idle_busy", 32'(bus.busy), 32'h0);

    // Asynchronous reset mid-sweep
    mode = 2;
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(bus.busy), 32'h1);
    chk("mid_ctt_before", 32'(bus.captured_tt), 32'h06);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    done_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_cnt++;
      if (n == 3) rst_n = 1'b1;
    end
    chk("mid_no_done", 32'(done_cnt), 32'd0);
    mode = 0;
    pulse_start();
    wait_done(lat);
    chk("post_rst_latency", 32'(lat), 32'd25);
    chk("post_rst_pass", 32'(bus.pass), 32'h1);
    chk("post_rst_ctt", 32'(bus.captured_tt), 32'hE8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
